// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the sequence-detector scheduler slice.
package seq_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_WORD_W = 16;
  localparam int DEF_CNT_W  = 5;

  // A single requester still needs a one-bit index signal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping around the request vector.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             valid
);

  always_comb begin
    grant    = '0;
    grant_id = '0;
    valid    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && req[(int'(rr_ptr) + k) % N_REQ]) begin
        valid                                = 1'b1;
        grant[(int'(rr_ptr) + k) % N_REQ]    = 1'b1;
        grant_id                             = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin front end that time-shares one serial sequence detector among
// N_REQ requesters and returns a saturating hit count for each word.
module seq_det_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WORD_W-1:0]    req_word,
  output logic [N_REQ-1:0]           ack,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [CNT_W-1:0]           hit_count,
  output logic                       det_rst,
  output logic                       det_in,
  input  logic                       det_out
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  sched_state_t      state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, cur_id, grant_id;
  logic [N_REQ-1:0]  grant;
  logic              grant_valid;
  logic [WORD_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  hit_cnt, hit_inc;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .valid    (grant_valid)
  );

  assign hit_inc = (det_out && (hit_cnt != {CNT_W{1'b1}})) ? hit_cnt + 1'b1 : hit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ack is gated by rst so it reads zero while reset is held with req pending.
  always_comb begin
    state_nxt = state;
    ack       = '0;
    det_in    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = CLEAR;
          ack       = rst ? grant : '0;
        end
      end
      CLEAR: state_nxt = SHIFT;
      SHIFT: begin
        det_in = shreg[WORD_W-1];
        if (bit_cnt == LAST_BIT) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SHIFT cycle 0 sees the detector straight out of reset, so it is not sampled;
  // the DRAIN sample is folded directly into the reported count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      hit_cnt   <= '0;
      det_rst   <= 1'b1;
      done_id   <= '0;
      hit_count <= '0;
    end else begin
      det_rst <= (state_nxt == CLEAR);
      case (state)
        IDLE: begin
          if (grant_valid) begin
            shreg  <= req_word[int'(grant_id)*WORD_W +: WORD_W];
            cur_id <= grant_id;
          end
        end
        CLEAR: begin
          bit_cnt <= '0;
          hit_cnt <= '0;
        end
        SHIFT: begin
          shreg   <= {shreg[WORD_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt != '0) hit_cnt <= hit_inc;
        end
        DRAIN: begin
          hit_count <= hit_inc;
          done_id   <= cur_id;
          rr_ptr    <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
